// File: rtl/serial_add_if.sv
// serial_add_if: host-side bundle for serial_add_ctrl (start/operands in, busy/done/result out).
// Ports (modport slave = controller view):
//   start  in   request, sampled only while idle
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   sub    in   subtract select (present only with SERIAL_SUB_EN defined)
//   busy   out  high while the bit-serial operation runs
//   done   out  one-cycle result-valid pulse
//   sum    out  WIDTH-bit registered result
//   cout   out  registered final carry (no-borrow flag when subtracting)
// Optional feature macro: SERIAL_SUB_EN.
interface serial_add_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add (and optional subtract) of WIDTH-bit words on one full-adder cell, LSB first.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    serial_add_if.slave: start/a/b/(sub) in, busy/done/sum/cout out
// Parameter WIDTH (2..64). Optional feature macro: SERIAL_SUB_EN (subtract via ~b and carry-in 1).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst_n,
    serial_add_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] ra, rb, rs, sum_q, nsum;
    logic [CW-1:0]    cnt;
    logic             carry, cout_q, fa_s, fa_c, last, sub_sel;

`ifdef SERIAL_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign fa_s = ra[0] ^ rb[0] ^ carry;
    assign fa_c = (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
    assign last = cnt == CW'(WIDTH - 1);
    // New sum bit enters at the MSB; after WIDTH steps the LSB has reached bit 0.
    assign nsum = WIDTH'({fa_s, rs} >> 1);

    always_comb begin
        nxt = state;
        if (state == IDLE && bus.start) nxt = RUN;
        if (state == RUN && last) nxt = DONE;
        if (state == DONE) nxt = IDLE;
    end

    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            rs     <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start) begin
                ra    <= bus.a;
                rb    <= sub_sel ? ~bus.b : bus.b;
                carry <= sub_sel;
                cnt   <= '0;
            end else if (state == RUN) begin
                ra    <= ra >> 1;
                rb    <= rb >> 1;
                rs    <= nsum;
                carry <= fa_c;
                cnt   <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    sum_q  <= nsum;
                    cout_q <= fa_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized scoreboard bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        int           e;
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    exp_t         q[$];
    int           checks = 0, errors = 0, cyc = 0, next_free = 0;
    logic [W-1:0] held_s = '0;
    logic         held_c = 1'b0;
    logic         clk = 1'b0, rst_n = 1'b1;
    logic         exp_done, exp_busy;

    always #5 clk = ~clk;

    serial_add_if #(.WIDTH(W)) bus();
    serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (edge %0d)", n, got, want, cyc);
        end
    endtask

    // Sum modulo 2^W with carry out; subtract yields difference and a no-borrow flag.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
        return sb ? {x >= y, W'(x - y)} : {1'b0, x} + {1'b0, y};
    endfunction

    // Monitor: compare handshake every cycle, pop the scoreboard on a done cycle.
    always @(negedge clk) begin
        exp_done = q.size() > 0 && cyc == q[0].e;
        exp_busy = q.size() > 0 && cyc >= q[0].e - W && cyc < q[0].e;
        chk("busy", 64'(bus.busy), 64'(exp_busy));
        chk("done", 64'(bus.done), 64'(exp_done));
        if (exp_done) begin
            held_s = q[0].s;
            held_c = q[0].c;
            void'(q.pop_front());
        end
        chk("sum", 64'(bus.sum), 64'(held_s));
        chk("cout", 64'(bus.cout), 64'(held_c));
    end

    task automatic step(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
        logic [W:0] r;
        logic       eff;
`ifdef SERIAL_SUB_EN
        eff = sb;
        bus.sub = sb;
`else
        eff = 1'b0 & sb;
`endif
        bus.start = s;
        bus.a = x;
        bus.b = y;
        if (s && rst_n && cyc + 1 >= next_free) begin
            r = model(x, y, eff);
            q.push_back('{e: cyc + 1 + W, s: r[W-1:0], c: r[W]});
            next_free = cyc + 1 + W + 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
        while (cyc + 1 < next_free) step(1'b0, W'($urandom), W'($urandom), 1'b0);
        step(1'b1, x, y, sb);
    endtask

    task automatic reset_now();
        bus.start = 1'b0;
        rst_n = 1'b0;
        q.delete();
        held_s = '0;
        held_c = 1'b0;
        next_free = 0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef SERIAL_SUB_EN
        bus.sub = 1'b0;
`endif
        @(posedge clk);
        #1;
        reset_now();
        repeat (5) step(1'b0, W'($urandom), W'($urandom), 1'b0);
        op(8'h35, 8'h4A, 1'b0);
        op(8'hFF, 8'h01, 1'b0);
        op(8'hFF, 8'hFF, 1'b0);
        op(8'h00, 8'h00, 1'b0);
        while (cyc + 1 < next_free) step(1'b0, '0, '0, 1'b0);
        // Continuous start; operands scrambled whenever a start would be ignored.
        repeat (35) begin
            if (cyc + 1 >= next_free) step(1'b1, 8'h10, 8'h20, 1'b0);
            else step(1'b1, W'($urandom), W'($urandom), 1'b0);
        end
        repeat (200) step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        repeat (30) begin
            repeat ($urandom_range(0, 3)) step(1'b0, W'($urandom), W'($urandom), 1'b0);
            op(W'($urandom), W'($urandom), 1'($urandom));
        end
        op(8'h35, 8'h4A, 1'b0);
        repeat (3) step(1'b0, W'($urandom), W'($urandom), 1'b0);
        reset_now();
        op(8'h35, 8'h4A, 1'b0);
`ifdef SERIAL_SUB_EN
        op(8'h50, 8'h20, 1'b1);
        op(8'h20, 8'h50, 1'b1);
        op(8'h77, 8'h77, 1'b1);
`endif
        repeat (W + 3) step(1'b0, '0, '0, 1'b0);
        chk("drain", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
